// File: rtl/data_memory_responder.sv
// Responder for the memory-access stage: word-addressed data RAM answered after a fixed
// latency over valid/ready. Define DATA_MEMORY_BOUNDS_CHECK_EN to flag out-of-range addresses.
module data_memory_responder #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_BITS  = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0] instruction_out,
  output logic                  mem_error
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // a response transfers on a rising edge with resp_valid && resp_ready.
  // Only one request is in flight, so req_ready is low from acceptance until the
  // response has been taken.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic                    err_q, err_d;
  logic                    mem_we;
  logic                    out_of_range;
  logic                    unused_high_bits;
  logic [ADDR_BITS-1:0]    idx;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign idx              = address[ADDR_BITS-1:0];
  assign unused_high_bits = |(address >> ADDR_BITS);

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  assign out_of_range = unused_high_bits;
`else
  // High address bits alias into the RAM.
  assign out_of_range = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    instr_d = instr_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          instr_d = instruction;
          err_d   = out_of_range;
          mem_we  = write_enable && !out_of_range;
          rdata_d = (write_enable || out_of_range) ? '0 : mem[idx];
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // RAM is deliberately not reset; a store accepted before reset stays committed.
  always_ff @(posedge clock) begin
    if (mem_we) mem[idx] <= write_data;
  end

  assign req_ready       = (state_q == IDLE);
  assign resp_valid      = (state_q == RESP);
  assign read_data       = rdata_q;
  assign instruction_out = instr_q;
  assign mem_error       = err_q && (state_q == RESP);

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: a LATENCY=2 and a LATENCY=1 instance share the request
// bus; a select bit routes handshakes and a memory-map model predicts every response.
module tb_data_memory_responder;

  localparam int DW = 20;

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clock;
  logic          reset_n;
  logic          sel;
  logic          req_valid;
  logic          resp_ready;
  logic [DW-1:0] address;
  logic [DW-1:0] write_data;
  logic          write_enable;
  logic [DW-1:0] instruction;

  logic          req_ready0, resp_valid0, mem_error0;
  logic [DW-1:0] read_data0, instr_out0;
  logic          req_ready1, resp_valid1, mem_error1;
  logic [DW-1:0] read_data1, instr_out1;

  logic          m_req_ready, m_resp_valid, m_mem_error;
  logic [DW-1:0] m_read_data, m_instr_out;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] ref_mem [2][256];
  bit            known   [2][256];

  data_memory_responder #(.DATA_WIDTH(DW), .ADDR_BITS(8), .LATENCY(2)) u_dut_l2 (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid && !sel),
    .req_ready       (req_ready0),
    .address         (address),
    .write_data      (write_data),
    .write_enable    (write_enable),
    .instruction     (instruction),
    .resp_valid      (resp_valid0),
    .resp_ready      (resp_ready && !sel),
    .read_data       (read_data0),
    .instruction_out (instr_out0),
    .mem_error       (mem_error0)
  );

  data_memory_responder #(.DATA_WIDTH(DW), .ADDR_BITS(8), .LATENCY(1)) u_dut_l1 (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid && sel),
    .req_ready       (req_ready1),
    .address         (address),
    .write_data      (write_data),
    .write_enable    (write_enable),
    .instruction     (instruction),
    .resp_valid      (resp_valid1),
    .resp_ready      (resp_ready && sel),
    .read_data       (read_data1),
    .instruction_out (instr_out1),
    .mem_error       (mem_error1)
  );

  assign m_req_ready  = sel ? req_ready1  : req_ready0;
  assign m_resp_valid = sel ? resp_valid1 : resp_valid0;
  assign m_mem_error  = sel ? mem_error1  : mem_error0;
  assign m_read_data  = sel ? read_data1  : read_data0;
  assign m_instr_out  = sel ? instr_out1  : instr_out0;

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction on the selected instance, with `stall` cycles of
  // resp_ready low once the response is up; junk requests are offered while stalled.
  task automatic txn(input bit we, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic [DW-1:0] instr, input int stall);
    int            lat;
    int            n;
    int            idx;
    bit            oor;
    bit            chk_rd;
    logic [DW-1:0] exp_rd;
    lat = sel ? 1 : 2;
    n   = 0;
    while (!m_req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("req_ready_before_request", m_req_ready, 1);

    idx = int'(addr) % 256;
    oor = BOUNDS && (addr >= 256);
    if (we) begin
      exp_rd = '0;
      chk_rd = 1'b1;
      if (!oor) begin
        ref_mem[sel][idx] = wdata;
        known[sel][idx]   = 1'b1;
      end
    end else if (oor) begin
      exp_rd = '0;
      chk_rd = 1'b1;
    end else begin
      exp_rd = ref_mem[sel][idx];
      chk_rd = known[sel][idx];
    end

    req_valid    = 1'b1;
    write_enable = we;
    address      = addr;
    write_data   = wdata;
    instruction  = instr;
    resp_ready   = 1'($urandom_range(0, 1));
    @(posedge clock);

    for (int k = 1; k <= lat; k++) begin
      @(negedge clock);
      if (k == 1) req_valid = 1'b0;
      if (k < lat) begin
        check("busy_resp_valid", m_resp_valid, 0);
        check("busy_req_ready", m_req_ready, 0);
        resp_ready = 1'($urandom_range(0, 1));
        @(posedge clock);
      end
    end

    check("resp_valid_at_latency", m_resp_valid, 1);
    check("resp_req_ready", m_req_ready, 0);
    if (chk_rd) check("read_data", m_read_data, exp_rd);
    check("instruction_out", m_instr_out, instr);
    check("mem_error", m_mem_error, oor);
    resp_ready = (stall == 0);

    for (int s = 0; s < stall; s++) begin
      req_valid    = 1'b1;
      write_enable = 1'($urandom_range(0, 1));
      address      = DW'($urandom_range(0, 15));
      write_data   = DW'($urandom);
      instruction  = DW'($urandom);
      @(posedge clock);
      @(negedge clock);
      check("stall_resp_valid", m_resp_valid, 1);
      check("stall_req_ready", m_req_ready, 0);
      if (chk_rd) check("stall_read_data", m_read_data, exp_rd);
      check("stall_instruction_out", m_instr_out, instr);
      if (s == stall - 1) resp_ready = 1'b1;
    end

    @(posedge clock);
    @(negedge clock);
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("after_resp_valid", m_resp_valid, 0);
    check("after_req_ready", m_req_ready, 1);
    check("after_mem_error", m_mem_error, 0);
  endtask

  initial begin
    logic [DW-1:0] a;
    reset_n      = 1'b0;
    sel          = 1'b0;
    req_valid    = 1'b0;
    resp_ready   = 1'b0;
    address      = '0;
    write_data   = '0;
    write_enable = 1'b0;
    instruction  = '0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) known[s][i] = 1'b0;

    // reset values on both instances
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("reset_req_ready", m_req_ready, 1);
      check("reset_resp_valid", m_resp_valid, 0);
      check("reset_read_data", m_read_data, 0);
      check("reset_instruction_out", m_instr_out, 0);
      check("reset_mem_error", m_mem_error, 0);
    end
    sel = 1'b0;
    @(negedge clock);

    // store then load, LATENCY=2
    txn(1'b1, 20'h00005, 20'hABCDE, 20'h12345, 0);
    txn(1'b0, 20'h00005, 20'h00000, 20'h54321, 0);

    // long back-pressure on a load
    txn(1'b0, 20'h00005, 20'h00000, 20'h0BEEF, 5);
    txn(1'b0, 20'h00005, 20'h00000, 20'h0CAFE, 0);

    // LATENCY=1 back-to-back loads with req_valid held high
    sel = 1'b1;
    txn(1'b1, 20'h00001, 20'h11111, 20'h0A001, 0);
    txn(1'b1, 20'h00002, 20'h22222, 20'h0A002, 0);
    req_valid    = 1'b1;
    write_enable = 1'b0;
    address      = 20'h00001;
    instruction  = 20'h0B001;
    resp_ready   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("b2b_first_valid", m_resp_valid, 1);
    check("b2b_first_data", m_read_data, 20'h11111);
    check("b2b_first_instr", m_instr_out, 20'h0B001);
    address     = 20'h00002;
    instruction = 20'h0B002;
    @(posedge clock);
    @(negedge clock);
    check("b2b_gap_valid", m_resp_valid, 0);
    check("b2b_gap_ready", m_req_ready, 1);
    @(posedge clock);
    @(negedge clock);
    check("b2b_second_valid", m_resp_valid, 1);
    check("b2b_second_data", m_read_data, 20'h22222);
    check("b2b_second_instr", m_instr_out, 20'h0B002);
    req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    check("b2b_end_valid", m_resp_valid, 0);
    sel = 1'b0;

    // reset during BUSY of a load; earlier store survives
    txn(1'b1, 20'h00003, 20'h33333, 20'h0C003, 0);
    req_valid    = 1'b1;
    write_enable = 1'b0;
    address      = 20'h00003;
    instruction  = 20'h0C004;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("pre_reset_busy", m_resp_valid, 0);
    reset_n = 1'b0;
    #1;
    check("midreset_resp_valid", m_resp_valid, 0);
    check("midreset_read_data", m_read_data, 0);
    check("midreset_instruction_out", m_instr_out, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("postreset_no_resp", m_resp_valid, 0);
      check("postreset_req_ready", m_req_ready, 1);
    end
    txn(1'b0, 20'h00003, 20'h00000, 20'h0C005, 1);

    // high address bits: flagged or aliased depending on build
    txn(1'b1, 20'h00105, 20'h00777, 20'h0D001, 0);
    txn(1'b0, 20'h00005, 20'h00000, 20'h0D002, 0);
    txn(1'b0, 20'h00105, 20'h00000, 20'h0D003, 0);

    // randomized traffic on both instances
    for (int t = 0; t < 40; t++) begin
      sel = 1'($urandom_range(0, 1));
      a   = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = a | (DW'($urandom_range(1, 4095)) << 8);
      txn(1'($urandom_range(0, 1)), a, DW'($urandom), DW'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
